mem_port_arbiter: RTL

- Shares the single main-memory port between the instruction-cache refill path (read-only) and the data-cache refill/writeback path (read/write).
- Sits between both cache miss/eviction interfaces and main memory.
- Each transaction is one 32-bit word, sequenced by a small FSM with registered memory-side outputs.
- Fixed data-side priority, bounded by a fairness counter so the instruction side cannot starve.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-side, D-side and main-memory signals around mem_port_arbiter.
// slave = arbiter view, master = requesters plus memory (testbench view).
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
) ();
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_rdata;
  logic            i_ack;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_ack;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            busy;
  logic            err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           busy, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache refill and D-cache refill/writeback.
// One word per transaction, D-side priority limited by a streak counter, all outputs registered.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_ACK_I, S_ACK_D} state_t;

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [3:0]    MAX_S    = 4'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t          r_st, w_st_n;
  logic            r_mem_req, w_mem_req_n;
  logic            r_mem_we, w_mem_we_n;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr_n;
  logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_n;
  logic            r_i_ack, w_i_ack_n;
  logic            r_d_ack, w_d_ack_n;
  logic [XLEN-1:0] r_i_rdata, w_i_rdata_n;
  logic [XLEN-1:0] r_d_rdata, w_d_rdata_n;
  logic            r_busy;
  logic            r_err, w_err_n;
  logic [3:0]      r_streak, w_streak_n;
  logic [TW-1:0]   r_tmo, w_tmo_n;
  logic            w_is_d;
  logic            w_done;
  logic [XLEN-1:0] w_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st        <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_streak    <= '0;
      r_tmo       <= '0;
    end else begin
      r_st        <= w_st_n;
      r_mem_req   <= w_mem_req_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_i_ack     <= w_i_ack_n;
      r_d_ack     <= w_d_ack_n;
      r_i_rdata   <= w_i_rdata_n;
      r_d_rdata   <= w_d_rdata_n;
      r_busy      <= (w_st_n != S_IDLE);
      r_err       <= w_err_n;
      r_streak    <= w_streak_n;
      r_tmo       <= w_tmo_n;
    end
  end

  always_comb begin
    w_st_n        = r_st;
    w_mem_req_n   = r_mem_req;
    w_mem_we_n    = r_mem_we;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_i_ack_n     = 1'b0;
    w_d_ack_n     = 1'b0;
    w_i_rdata_n   = '0;
    w_d_rdata_n   = '0;
    w_err_n       = r_err;
    w_streak_n    = r_streak;
    w_tmo_n       = r_tmo;
    w_is_d        = (r_st == S_BUSY_D);
    w_done        = 1'b0;
    w_rd          = '0;

    case (r_st)
      S_IDLE: begin
        if (bus.d_req && (!bus.i_req || r_streak < MAX_S)) begin
          w_st_n        = S_BUSY_D;
          w_mem_req_n   = 1'b1;
          w_mem_we_n    = bus.d_we;
          w_mem_addr_n  = bus.d_addr;
          w_mem_wdata_n = bus.d_we ? bus.d_wdata : '0;
          w_tmo_n       = '0;
          // Streak only grows while I is actually waiting.
          if (!bus.i_req)            w_streak_n = '0;
          else if (r_streak != MAX_S) w_streak_n = r_streak + 4'd1;
        end else if (bus.i_req) begin
          w_st_n        = S_BUSY_I;
          w_mem_req_n   = 1'b1;
          w_mem_we_n    = 1'b0;
          w_mem_addr_n  = bus.i_addr;
          w_mem_wdata_n = '0;
          w_tmo_n       = '0;
          w_streak_n    = '0;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (bus.mem_ready) begin
          w_done = 1'b1;
          w_rd   = r_mem_we ? '0 : bus.mem_rdata;
        end else if (r_tmo == TMO_LAST) begin
          // Abort: release the requester with zero data and flag the fault.
          w_done  = 1'b1;
          w_err_n = 1'b1;
        end else begin
          w_tmo_n = r_tmo + 1'b1;
        end
        if (w_done) begin
          w_st_n        = w_is_d ? S_ACK_D : S_ACK_I;
          w_mem_req_n   = 1'b0;
          w_mem_we_n    = 1'b0;
          w_mem_addr_n  = '0;
          w_mem_wdata_n = '0;
          w_i_ack_n     = !w_is_d;
          w_d_ack_n     = w_is_d;
          w_i_rdata_n   = w_is_d ? '0 : w_rd;
          w_d_rdata_n   = w_is_d ? w_rd : '0;
        end
      end
      S_ACK_I, S_ACK_D: w_st_n = S_IDLE;
      default: w_st_n = S_IDLE;
    endcase
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_ack     = r_i_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule
